mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage RV32I pipeline, directly downstream of the execute stage. Takes the ALU result as the effective address plus the forwarded rs2 value, issues one data-memory read or write, and stalls the pipeline until the response. Produces width-aligned, sign/zero-extended load data for the MEM/WB register and passes non-memory instructions through with zero added latency.

## Interface
- Parameters: none. Data and address width are fixed at 32.
- Reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-high reset.
- `valid_in` in 1: EX/MEM register holds a live instruction.
- `mem_read` in 1: instruction is a load.
- `mem_write` in 1: instruction is a store.
- `funct3` in 3: load/store width encoding.
- `alu_out` in 32: effective address from the execute stage.
- `rs2_out` in 32: store data, already forwarded.
- `advance` in 1: the whole pipeline moves this edge; no other stage is stalling.
- `data_rdata` in 32: memory read data, valid with `data_resp`.
- `data_resp` in 1: one-cycle memory completion pulse.
- `data_read` out 1: read request, held until `data_resp`.
- `data_write` out 1: write request, held until `data_resp`.
- `data_mbe` out 4: byte enables for stores; 4'b0000 on reads.
- `data_addr` out 32: word-aligned address `{alu_out[31:2],2'b00}`.
- `data_wdata` out 32: store data shifted to byte lane.
- `mem_stall` out 1: this stage holds the pipeline.
- `load_data` out 32: formatted load result.
- `misaligned` out 1: access rejected because of its alignment.

## Operation
- FSM states and transitions:
  - IDLE → BUSY when `valid_in` is high, a memory op is present, and the access is legal. On that edge, register `data_addr`, `data_wdata`, `data_mbe` and the request type.
  - BUSY: drive `data_read` or `data_write` from registers. On `data_resp`, latch the formatted `data_rdata` (loads only) into `load_data` and go to DONE.
  - DONE → IDLE when `advance` is high. Otherwise hold DONE and keep `load_data` stable.
- `mem_stall` is combinational:
  - 1 in IDLE when a legal memory op is present.
  - 1 in BUSY.
  - 0 in DONE and for non-memory or rejected instructions.
- Stores, by `funct3`:
  - SB (000): `mbe = 4'b0001 << a[1:0]`, `wdata = rs2 << 8*a[1:0]`.
  - SH (001): `mbe = 4'b0011 << a[1:0]`, `wdata = rs2 << 8*a[1:0]`.
  - SW (010): `mbe = 4'b1111`, `wdata = rs2`.
- Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Select the byte or half at `a[1:0]` from `data_rdata`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- Misalignment:
  - LH, LHU or SH with `a[0]=1` is misaligned.
  - LW or SW with `a[1:0]≠0` is misaligned.
  - A misaligned access issues no request and does not stall.
  - `misaligned` is combinational and high while that instruction is present in IDLE.
- Illegal load `funct3` (011/110/111) or store `funct3` ≥011: no request, no stall, `misaligned=0`.
- `mem_read` and `mem_write` both high: the read is performed and the write is ignored.
- `data_resp` in IDLE or DONE is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `data_read`, `data_write` = 0.
  - `data_mbe` = 0.
  - `data_addr`, `data_wdata` = 0.
  - `load_data` = 0.
  - `misaligned` = 0.
  - `mem_stall` = 0 while `valid_in` is low.
- Memory-op sequence:
  - Cycle 0: instruction arrives, IDLE, `mem_stall=1`.
  - Cycle 1: BUSY, request asserted.
  - Response at cycle n≥1: DONE at n+1 with `mem_stall=0` and `load_data` valid.
  - With `advance=1` at n+1, the next instruction arrives at n+2.
- Minimum cost of a memory op is 2 stall cycles.
- Requests stay stable from assertion through the `data_resp` cycle and drop the cycle after.
- `rst` mid-BUSY: requests drop immediately (asynchronous); a late `data_resp` is ignored.
- `advance=0` in DONE: hold indefinitely with no re-request.

## Structure
- `rv32i_types` holds `load_funct3_t` and `store_funct3_t`; add them there if absent.
- The FSM state enum is local to `mem_stage`.
- Sub-module `mem_load_format`: combinational function of (`funct3`, `a[1:0]`, `data_rdata`) producing the extended load value.

## Test plan
- LW from address 0x100, memory returns 0xDEADBEEF after 3 cycles → `data_read` high 3 cycles, `data_mbe=0`, `load_data=0xDEADBEEF`, `mem_stall` high 4 cycles total.
- LB from 0x103 with rdata 0x80FF0000 → `load_data=0xFFFFFF80`; LBU from the same address → `load_data=0x00000080`.
- SH to 0x202 with rs2=0x1234ABCD → `data_addr=0x200`, `data_mbe=4'b1100`, `data_wdata=0xABCD0000`, `data_write` held until resp.
- LW from 0x101 → no request, `misaligned=1`, `mem_stall=0`.
- Load completes with `advance=0` for 5 cycles → stays DONE, `load_data` stable, no second request; moves to IDLE on the `advance=1` edge.
- Assert `rst` during BUSY, then pulse `data_resp` → `data_read` drops at once, state IDLE, `load_data=0`, and the response is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Constants and decode helpers for the memory-access stage.
// Helpers are pure functions of funct3 and the low address bits.
package mem_stage_pkg;
  import rv32i_types::*;

  localparam int XLEN = 32;

  function automatic logic isLegalLoad(input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic isLegalStore(input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    case (funct3)
      F3_SB, F3_SH, F3_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  // For every legal load/store encoding funct3[1:0] gives the access size.
  function automatic logic accessMisaligned(input logic [2:0] funct3,
                                            input logic [1:0] addrLow);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = addrLow[0];
      2'b10:   mis = |addrLow;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] storeMask(input logic [2:0] funct3,
                                           input logic [1:0] addrLow);
    logic [3:0] mask;
    mask = 4'b0000;
    case (funct3)
      F3_SB:   mask = 4'b0001 << addrLow;
      F3_SH:   mask = 4'b0011 << addrLow;
      F3_SW:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [XLEN-1:0] storeData(input logic [2:0] funct3,
                                                input logic [1:0] addrLow,
                                                input logic [XLEN-1:0] rs2);
    logic [XLEN-1:0] data;
    data = '0;
    case (funct3)
      F3_SB, F3_SH: data = rs2 << {addrLow, 3'b000};
      F3_SW:        data = rs2;
      default:      data = '0;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I encodings used across pipeline stages.
// Load and store width fields of funct3.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of EX/MEM inputs, data-memory bus and MEM/WB results.
// master is the memory stage's view, slave is the pipeline/memory side.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic            valid_in;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      funct3;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] rs2_out;
  logic            advance;
  logic [XLEN-1:0] data_rdata;
  logic            data_resp;
  logic            data_read;
  logic            data_write;
  logic [3:0]      data_mbe;
  logic [XLEN-1:0] data_addr;
  logic [XLEN-1:0] data_wdata;
  logic            mem_stall;
  logic [XLEN-1:0] load_data;
  logic            misaligned;

  modport master (
    input  valid_in, mem_read, mem_write, funct3, alu_out, rs2_out,
           advance, data_rdata, data_resp,
    output data_read, data_write, data_mbe, data_addr, data_wdata,
           mem_stall, load_data, misaligned
  );

  modport slave (
    output valid_in, mem_read, mem_write, funct3, alu_out, rs2_out,
           advance, data_rdata, data_resp,
    input  data_read, data_write, data_mbe, data_addr, data_wdata,
           mem_stall, load_data, misaligned
  );

endinterface

// File: rtl/mem_stage_load_format.sv
// Extracts the addressed byte/half/word from a read word and extends it.
module mem_load_format
  import rv32i_types::*;
  import mem_stage_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addrLow,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_loadData
);

  logic [XLEN-1:0] w_shifted;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  // Move the addressed lane down to bit 0 before extension.
  assign w_shifted = i_rdata >> {i_addrLow, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  always_comb begin
    o_loadData = '0;
    case (i_funct3)
      F3_LB:   o_loadData = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_loadData = {{16{w_half[15]}}, w_half};
      F3_LW:   o_loadData = i_rdata;
      F3_LBU:  o_loadData = {24'd0, w_byte};
      F3_LHU:  o_loadData = {16'd0, w_half};
      default: o_loadData = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues one data-memory request per load/store,
// stalls until the response, and holds the formatted load result for MEM/WB.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.master io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_read;
  logic            r_write;
  logic [3:0]      r_mbe;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_loadData;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addrLow;

  logic            w_isLoad;
  logic            w_isStore;
  logic            w_legal;
  logic            w_misAccess;
  logic            w_accept;
  logic [XLEN-1:0] w_loadFmt;

  // A load wins when both mem_read and mem_write are set.
  assign w_isLoad    = io_bus.valid_in & io_bus.mem_read;
  assign w_isStore   = io_bus.valid_in & io_bus.mem_write & ~io_bus.mem_read;
  assign w_legal     = w_isLoad  ? isLegalLoad(io_bus.funct3) :
                       w_isStore ? isLegalStore(io_bus.funct3) : 1'b0;
  assign w_misAccess = w_legal & accessMisaligned(io_bus.funct3, io_bus.alu_out[1:0]);
  assign w_accept    = w_legal & ~w_misAccess;

  mem_load_format u_loadFormat (
    .i_funct3   (r_funct3),
    .i_addrLow  (r_addrLow),
    .i_rdata    (io_bus.data_rdata),
    .o_loadData (w_loadFmt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_mbe      <= 4'b0000;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_loadData <= '0;
      r_funct3   <= 3'b000;
      r_addrLow  <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_BUSY;
            r_read    <= w_isLoad;
            r_write   <= w_isStore;
            r_addr    <= {io_bus.alu_out[XLEN-1:2], 2'b00};
            r_mbe     <= w_isStore ? storeMask(io_bus.funct3, io_bus.alu_out[1:0]) : 4'b0000;
            r_wdata   <= w_isStore ?
                         storeData(io_bus.funct3, io_bus.alu_out[1:0], io_bus.rs2_out) : '0;
            r_funct3  <= io_bus.funct3;
            r_addrLow <= io_bus.alu_out[1:0];
          end
        end
        ST_BUSY: begin
          if (io_bus.data_resp) begin
            r_state <= ST_DONE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_read) begin
              r_loadData <= w_loadFmt;
            end
          end
        end
        ST_DONE: begin
          if (io_bus.advance) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.data_read  = r_read;
  assign io_bus.data_write = r_write;
  assign io_bus.data_mbe   = r_mbe;
  assign io_bus.data_addr  = r_addr;
  assign io_bus.data_wdata = r_wdata;
  assign io_bus.load_data  = r_loadData;
  assign io_bus.mem_stall  = ((r_state == ST_IDLE) & w_accept) | (r_state == ST_BUSY);
  assign io_bus.misaligned = (r_state == ST_IDLE) & w_misAccess;

endmodule
